// File: rtl/cpx_pkg.sv
// Shared types and helpers for the fixed-point complex multiplier.
// Words pack the real part in the upper half and the imaginary part in the lower half.
package cpx_pkg;

  localparam int WORD_SZ   = 32;
  localparam int WORD_MID  = WORD_SZ / 2;
  localparam int FRAC_BITS = 6;

  typedef logic signed [WORD_MID-1:0]   cpx_comp_t;
  typedef logic signed [2*WORD_MID-1:0] cpx_prod_t;
  typedef logic signed [2*WORD_MID:0]   cpx_wide_t;

  typedef struct packed {
    cpx_comp_t re;
    cpx_comp_t im;
  } cpx_word_t;

  function automatic cpx_word_t cpx_unpack(input logic [WORD_SZ-1:0] word);
    cpx_word_t w;
    w.re = word[WORD_SZ-1:WORD_MID];
    w.im = word[WORD_MID-1:0];
    return w;
  endfunction

  function automatic logic [WORD_SZ-1:0] cpx_pack(input cpx_comp_t re, input cpx_comp_t im);
    return {re, im};
  endfunction

endpackage

// File: rtl/complex_multiplier_if.sv
// Operand/result bundle for the complex multiplier; master drives operands, slave returns products.
interface complex_multiplier_if;
  import cpx_pkg::*;

  logic               in_valid;
  logic [WORD_SZ-1:0] cpx_A;
  logic [WORD_SZ-1:0] cpx_B;
  logic               out_valid;
  logic [WORD_SZ-1:0] cpx_C;
  logic               sat;

  modport master (
    output in_valid, cpx_A, cpx_B,
    input  out_valid, cpx_C, sat
  );

  modport slave (
    input  in_valid, cpx_A, cpx_B,
    output out_valid, cpx_C, sat
  );

endinterface

// File: rtl/cpx_round_sat.sv
// Rounds a 33-bit fixed-point sum half toward +inf, drops FRAC_BITS, and clamps to one component.
module cpx_round_sat #(
  parameter int FRAC_BITS = cpx_pkg::FRAC_BITS
) (
  input  cpx_pkg::cpx_wide_t val,
  output cpx_pkg::cpx_comp_t res,
  output logic               sat
);

  localparam logic signed [33:0] HALF_LSB = 34'sd1 <<< (FRAC_BITS - 1);
  localparam logic signed [33:0] MAX_POS  = 34'sd32767;
  localparam logic signed [33:0] MIN_NEG  = -34'sd32768;

  logic signed [33:0] sum_s;
  logic signed [33:0] shifted_s;

  // One extra guard bit keeps the rounding add from wrapping at the extremes.
  always_comb begin
    sum_s     = $signed({val[32], val}) + HALF_LSB;
    shifted_s = sum_s >>> FRAC_BITS;
    res       = shifted_s[15:0];
    sat       = 1'b0;
    if (shifted_s > MAX_POS) begin
      res = 16'sh7FFF;
      sat = 1'b1;
    end else if (shifted_s < MIN_NEG) begin
      res = 16'sh8000;
      sat = 1'b1;
    end else begin
      res = shifted_s[15:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/complex_multiplier.sv
// Two-stage pipelined fixed-point complex multiplier: partial products, then combine/round/saturate.
module complex_multiplier
  import cpx_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  complex_multiplier_if.slave bus
);

  cpx_word_t a_s;
  cpx_word_t b_s;
  cpx_comp_t ar_s, ai_s, br_s, bi_s;
  cpx_prod_t p_rr_s, p_ii_s, p_ri_s, p_ir_s;

  logic      v1_r;
  cpx_prod_t p_rr_r, p_ii_r, p_ri_r, p_ir_r;

  cpx_wide_t re_full_s, im_full_s;
  cpx_comp_t re_sat_s, im_sat_s;
  logic      re_flag_s, im_flag_s;

  logic               v2_r;
  logic [WORD_SZ-1:0] cpx_c_r;
  logic               sat_r;

  // Operand split and the four signed partial products.
  always_comb begin
    a_s    = cpx_unpack(bus.cpx_A);
    b_s    = cpx_unpack(bus.cpx_B);
    ar_s   = a_s.re;
    ai_s   = a_s.im;
    br_s   = b_s.re;
    bi_s   = b_s.im;
    p_rr_s = ar_s * br_s;
    p_ii_s = ai_s * bi_s;
    p_ri_s = ar_s * bi_s;
    p_ir_s = ai_s * br_s;
  end

  // Stage 1 register: products captured only on valid input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      p_rr_r <= '0;
      p_ii_r <= '0;
      p_ri_r <= '0;
      p_ir_r <= '0;
    end else begin
      v1_r <= bus.in_valid;
      if (bus.in_valid) begin
        p_rr_r <= p_rr_s;
        p_ii_r <= p_ii_s;
        p_ri_r <= p_ri_s;
        p_ir_r <= p_ir_s;
      end else begin
        p_rr_r <= p_rr_r;
        p_ii_r <= p_ii_r;
        p_ri_r <= p_ri_r;
        p_ir_r <= p_ir_r;
      end
    end
  end

  // Sign-extend to 33 bits so the combine cannot overflow.
  always_comb begin
    re_full_s = $signed({p_rr_r[31], p_rr_r}) - $signed({p_ii_r[31], p_ii_r});
    im_full_s = $signed({p_ri_r[31], p_ri_r}) + $signed({p_ir_r[31], p_ir_r});
  end

  cpx_round_sat #(.FRAC_BITS(FRAC_BITS)) u_rs_re (
    .val (re_full_s),
    .res (re_sat_s),
    .sat (re_flag_s)
  );

  cpx_round_sat #(.FRAC_BITS(FRAC_BITS)) u_rs_im (
    .val (im_full_s),
    .res (im_sat_s),
    .sat (im_flag_s)
  );

  // Stage 2 register: result and flag hold while no new data arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_r    <= 1'b0;
      cpx_c_r <= '0;
      sat_r   <= 1'b0;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        cpx_c_r <= cpx_pack(re_sat_s, im_sat_s);
        sat_r   <= re_flag_s | im_flag_s;
      end else begin
        cpx_c_r <= cpx_c_r;
        sat_r   <= sat_r;
      end
    end
  end

  assign bus.out_valid = v2_r;
  assign bus.cpx_C     = cpx_c_r;
  assign bus.sat       = sat_r;

endmodule

// File: tb/tb_complex_multiplier.sv
// Self-checking bench: directed vector table, pipeline/reset sequences, and randomized traffic vs a reference model.
module tb_complex_multiplier;
  import cpx_pkg::*;

  logic clk;
  logic rst_n;
  complex_multiplier_if bus ();

  complex_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        s;
  } vec_t;

  vec_t tv[7];
  int errors = 0;
  int checks = 0;

  // Expected-output pipeline: what was driven one and two cycles ago.
  logic        d1_v, d2_v;
  logic [31:0] d1_a, d1_b, d2_a, d2_b;
  logic [31:0] last_c;
  logic        last_s;

  // Floor division by 2^FRAC_BITS after adding half an LSB, then clamp to 16 bits.
  function automatic logic [15:0] ref_comp(input longint x, output logic s);
    longint q;
    longint one;
    one = longint'(1) << FRAC_BITS;
    q = x + one / 2;
    if (q >= 0) q = q / one;
    else        q = -((-q + one - 1) / one);
    s = 1'b0;
    if (q > 32767) begin q = 32767; s = 1'b1; end
    if (q < -32768) begin q = -32768; s = 1'b1; end
    return q[15:0];
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] c, output logic s);
    longint ar, ai, br, bi;
    logic sr, si;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    c[31:16] = ref_comp(ar * br - ai * bi, sr);
    c[15:0]  = ref_comp(ar * bi + ai * br, si);
    s = sr | si;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // One cycle: check outputs on the falling edge, then drive the next inputs.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic r);
    logic [31:0] ec;
    logic es;
    @(negedge clk);
    if (d2_v) begin
      model(d2_a, d2_b, ec, es);
      last_c = ec;
      last_s = es;
    end
    chk("out_valid", 32'(bus.out_valid), 32'(d2_v));
    chk("cpx_C", bus.cpx_C, last_c);
    chk("sat", 32'(bus.sat), 32'(last_s));
    rst_n        = r;
    bus.in_valid = v;
    bus.cpx_A    = a;
    bus.cpx_B    = b;
    if (!r) begin
      d1_v = 1'b0; d2_v = 1'b0; last_c = 32'h0; last_s = 1'b0;
    end else begin
      d2_v = d1_v; d2_a = d1_a; d2_b = d1_b;
      d1_v = v;    d1_a = a;    d1_b = b;
    end
  endtask

  function automatic logic [15:0] rand_comp();
    logic [31:0] r;
    r = $urandom;
    case (r[18:16])
      3'd0:    return 16'h8000;
      3'd1:    return 16'h7FFF;
      3'd2:    return 16'h0000;
      default: return r[15:0];
    endcase
  endfunction

  initial begin
    tv[0] = '{a: 32'h0040_0080, b: 32'h00C0_0100, c: 32'hFEC0_0280, s: 1'b0};
    tv[1] = '{a: 32'h0050_00A0, b: 32'h00E0_0110, c: 32'hFE70_0384, s: 1'b0};
    tv[2] = '{a: 32'hFE70_00A0, b: 32'h0110_FF60, c: 32'hFAEC_0690, s: 1'b0};
    tv[3] = '{a: 32'h0001_0000, b: 32'h0020_0000, c: 32'h0001_0000, s: 1'b0};
    tv[4] = '{a: 32'hFFFF_0000, b: 32'h0020_0000, c: 32'h0000_0000, s: 1'b0};
    tv[5] = '{a: 32'h8000_0000, b: 32'h8000_0000, c: 32'h7FFF_0000, s: 1'b1};
    tv[6] = '{a: 32'h8000_0000, b: 32'h7FFF_0000, c: 32'h8000_0000, s: 1'b1};

    d1_v = 1'b0; d2_v = 1'b0; d1_a = '0; d1_b = '0; d2_a = '0; d2_b = '0;
    last_c = 32'h0; last_s = 1'b0;
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.cpx_A = 32'h0; bus.cpx_B = 32'h0;

    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("reset out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset cpx_C", bus.cpx_C, 32'h0);

    // Directed table, one vector at a time, with an explicit latency check.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, tv[i].a, tv[i].b, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1);
      chk($sformatf("tv%0d cpx_C", i), bus.cpx_C, tv[i].c);
      chk($sformatf("tv%0d sat", i), 32'(bus.sat), 32'(tv[i].s));
      chk($sformatf("tv%0d out_valid", i), 32'(bus.out_valid), 32'h1);
    end

    // Commutativity on a saturating and a signed operand pair.
    step(1'b1, tv[6].b, tv[6].a, 1'b1);
    step(1'b1, tv[2].b, tv[2].a, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("swap sat cpx_C", bus.cpx_C, tv[6].c);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("swap signed cpx_C", bus.cpx_C, tv[2].c);

    // Back-to-back throughput.
    step(1'b1, tv[0].a, tv[0].b, 1'b1);
    step(1'b1, tv[1].a, tv[1].b, 1'b1);
    step(1'b1, tv[2].a, tv[2].b, 1'b1);
    chk("b2b first", bus.cpx_C, tv[0].c);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("b2b second", bus.cpx_C, tv[1].c);
    chk("b2b second valid", 32'(bus.out_valid), 32'h1);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("b2b third", bus.cpx_C, tv[2].c);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("b2b hold", bus.cpx_C, tv[2].c);

    // Reset with a result in flight: it must never appear.
    step(1'b1, tv[5].a, tv[5].b, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk("flush out_valid", 32'(bus.out_valid), 32'h0);
    chk("flush cpx_C", bus.cpx_C, 32'h0);
    chk("flush sat", 32'(bus.sat), 32'h0);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      r = $urandom;
      step(r[3:0] < 4'd11, {rand_comp(), rand_comp()}, {rand_comp(), rand_comp()},
           r[11:4] != 8'd0);
    end
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
